// File: rtl/apu_timer_sched.sv
// apu_timer_sched: time-multiplexed down-counter engine for the APU timers.
// A global tick launches a sweep that visits one channel per cycle through a
// single shared decrement/reload datapath. Ticks that arrive mid-sweep are
// queued in a small saturating counter. A tick that finds the queue full is
// dropped, and the drop is flagged as an overrun.
module apu_timer_sched #(
  parameter int N_TIMERS = 3,
  parameter int W_CTR    = 20,
  parameter int W_PEND   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick_i,
  input  logic [N_TIMERS-1:0]           en_i,
  input  logic [N_TIMERS-1:0]           reload_en_i,
  input  logic [N_TIMERS*W_CTR-1:0]     reload_i,
  input  logic                          wr_i,
  input  logic [$clog2(N_TIMERS)-1:0]   wr_sel_i,
  input  logic [W_CTR-1:0]              wr_data_i,
  input  logic [$clog2(N_TIMERS)-1:0]   rd_sel_i,
  output logic [W_CTR-1:0]              rd_data_o,
  output logic [N_TIMERS-1:0]           event_o,
  output logic                          busy_o,
  output logic                          overrun_o,
  input  logic                          overrun_clr_i
);

  localparam int W_IDX = $clog2(N_TIMERS);
  // Channel count widened by one bit so that out-of-range selects can be
  // detected without truncating N_TIMERS.
  localparam logic [W_IDX:0]    N_LIM    = (W_IDX+1)'(N_TIMERS);
  localparam logic [W_IDX-1:0]  LAST_IDX = W_IDX'(N_TIMERS - 1);
  localparam logic [W_PEND-1:0] PEND_MAX = {W_PEND{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [W_IDX-1:0]    idx_reg, idx_next;
  logic [W_PEND-1:0]   pend_reg, pend_next;
  logic                overrun_reg, overrun_next;
  logic                overrun_set;

  logic [W_CTR-1:0]    ctr_reg  [N_TIMERS];
  logic [W_CTR-1:0]    ctr_next [N_TIMERS];
  logic [N_TIMERS-1:0] event_reg, event_next;

  logic                wr_ok;

  // A write to a select beyond the last channel is ignored.
  assign wr_ok = wr_i && ({1'b0, wr_sel_i} < N_LIM);

  // Sweep control state, pending-tick queue and sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      pend_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      pend_reg    <= pend_next;
      overrun_reg <= overrun_next;
    end
  end

  // Next-state logic for the sweep FSM and queue. On the final channel of a
  // sweep, a queued tick (or one arriving that cycle) immediately starts the
  // next sweep with no idle gap.
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    pend_next   = pend_reg;
    overrun_set = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (tick_i) begin
          state_next = SWEEP;
          idx_next   = '0;
        end
      end
      SWEEP: begin
        if (idx_reg == LAST_IDX) begin
          idx_next = '0;
          if (tick_i) begin
            // Arrival and consumption cancel; the queue depth is unchanged.
            pend_next = pend_reg;
          end else if (pend_reg != '0) begin
            pend_next = pend_reg - 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          idx_next = idx_reg + 1'b1;
          if (tick_i) begin
            if (pend_reg == PEND_MAX) begin
              overrun_set = 1'b1;
            end else begin
              pend_next = pend_reg + 1'b1;
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
    // A new drop takes priority over a clear that arrives in the same cycle.
    if (overrun_set) begin
      overrun_next = 1'b1;
    end else if (overrun_clr_i) begin
      overrun_next = 1'b0;
    end else begin
      overrun_next = overrun_reg;
    end
  end

  // Shared counter datapath. A software write to a channel always wins.
  // Otherwise only the channel under the sweep index can reload or
  // decrement. A decrement from 1 to 0 raises that channel's event.
  always_comb begin
    event_next = '0;
    for (int i = 0; i < N_TIMERS; i++) begin
      ctr_next[i] = ctr_reg[i];
      if (wr_ok && (wr_sel_i == W_IDX'(i))) begin
        ctr_next[i] = wr_data_i;
      end else if ((state_reg == SWEEP) && (idx_reg == W_IDX'(i)) && en_i[i]) begin
        if (ctr_reg[i] == '0) begin
          if (reload_en_i[i]) begin
            ctr_next[i] = reload_i[i*W_CTR +: W_CTR];
          end
        end else begin
          ctr_next[i] = ctr_reg[i] - 1'b1;
          if (ctr_reg[i] == W_CTR'(1)) begin
            event_next[i] = 1'b1;
          end
        end
      end
    end
  end

  // Counter storage and the one-cycle expiry pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_TIMERS; i++) begin
        ctr_reg[i] <= '0;
      end
      event_reg <= '0;
    end else begin
      for (int i = 0; i < N_TIMERS; i++) begin
        ctr_reg[i] <= ctr_next[i];
      end
      event_reg <= event_next;
    end
  end

  // Read port shows committed counter state. An out-of-range select reads 0.
  always_comb begin
    rd_data_o = '0;
    if ({1'b0, rd_sel_i} < N_LIM) begin
      rd_data_o = ctr_reg[rd_sel_i];
    end
  end

  assign event_o   = event_reg;
  assign busy_o    = (state_reg == SWEEP);
  assign overrun_o = overrun_reg;

endmodule
